// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, in-order imem requests, prefetch FIFO and decode handshake.
// Optional misaligned-redirect fault, enabled by defining FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(2 * FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {RUN, FAULT} state_e;
`else
  typedef enum logic {RUN} state_e;
`endif

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     rspPc_q, rspPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   dropCnt_q, dropCnt_d;
  logic [CW-1:0]   fifoCnt_q, fifoCnt_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [31:0]     instrMem_q [FIFO_DEPTH];
  logic [31:0]     pcMem_q    [FIFO_DEPTH];

  logic            running;
  logic            accept;
  logic            dropRsp;
  logic            push;
  logic            pop;
  logic [CW:0]     committed;
  logic [31:0]     redirTarget;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misaligned;
  assign misaligned  = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = (state_q == FAULT);
`else
  logic            unusedRedirLsbs;
  assign unusedRedirLsbs = ^redirect_pc[1:0];
  assign fetch_fault     = 1'b0;
`endif

  assign redirTarget = {redirect_pc[31:2], 2'b00};
  assign if_instr    = instrMem_q[rdPtr_q];
  assign if_pc       = pcMem_q[rdPtr_q];

  // Responses are in order, so the PC of the next kept response is tracked
  // with one running address instead of a queue of issued addresses.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    rspPc_d        = rspPc_q;
    running        = !rst && (state_q == RUN);
    if_valid       = running && !redirect_valid && (fifoCnt_q != '0);
    pop            = if_valid && if_ready;
    // The head leaving this cycle frees its slot, which keeps a 1-cycle
    // memory streaming at one instruction per cycle.
    committed      = {1'b0, outstanding_q} - {1'b0, dropCnt_q}
                   + {1'b0, fifoCnt_q} - (CW+1)'(pop);
    imem_req_valid = running && !redirect_valid
                   && (committed < (CW+1)'(FIFO_DEPTH))
                   && (outstanding_q < CW'(2 * FIFO_DEPTH));
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;
    dropRsp        = imem_rsp_valid && (dropCnt_q != '0);
    push           = imem_rsp_valid && (dropCnt_q == '0) && !redirect_valid;

    outstanding_d  = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    dropCnt_d      = dropCnt_q - CW'(dropRsp);
    fifoCnt_d      = fifoCnt_q + CW'(push) - CW'(pop);
    wrPtr_d        = wrPtr_q + PW'(push);
    rdPtr_d        = rdPtr_q + PW'(pop);

    if (accept)
      pc_d = pc_q + 32'd4;
    if (push)
      rspPc_d = rspPc_q + 32'd4;

    if (redirect_valid) begin
      pc_d      = redirTarget;
      rspPc_d   = redirTarget;
      dropCnt_d = outstanding_q - CW'(imem_rsp_valid);
      fifoCnt_d = '0;
      wrPtr_d   = '0;
      rdPtr_d   = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      state_d   = misaligned ? FAULT : RUN;
`endif
    end
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      fifoCnt_q     <= '0;
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      fifoCnt_q     <= fifoCnt_d;
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
    end
  end

  // FIFO storage is cleared on reset so decode sees zero words until the first fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instrMem_q[i] <= '0;
        pcMem_q[i]    <= '0;
      end
    end else if (push) begin
      instrMem_q[wrPtr_q] <= imem_rsp_data;
      pcMem_q[wrPtr_q]    <= rspPc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: table-driven streaming/stall run
// plus hand-written redirect, wrap and misalignment sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int passCount  = 0;
  int totalCount = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        ifReady;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expIfValid;
    logic [31:0] expIfPc;
  } vec_t;

  vec_t vecs [20];

  // Instruction memory contents seen by the bench: a fixed pattern per address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic reqReady, input logic rspValid,
                               input logic [31:0] rspData, input logic redirValid,
                               input logic [31:0] redirPc, input logic ifReady);
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = reqReady;
    imem_rsp_valid = rspValid;
    imem_rsp_data  = rspData;
    redirect_valid = redirValid;
    redirect_pc    = redirPc;
    if_ready       = ifReady;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkReq(input string name, input logic expValid, input logic [31:0] expAddr);
    checkOutput({name, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, expValid});
    if (expValid)
      checkOutput({name, ".req_addr"}, imem_req_addr, expAddr);
  endtask

  task automatic checkIf(input string name, input logic expValid, input logic [31:0] expPc);
    checkOutput({name, ".if_valid"}, {31'b0, if_valid}, {31'b0, expValid});
    if (expValid) begin
      checkOutput({name, ".if_pc"}, if_pc, expPc);
      checkOutput({name, ".if_instr"}, if_instr, memWord(expPc));
    end
  endtask

  // Hold reset with a bogus response present, then check the reset values.
  task automatic doReset();
    @(negedge clk);
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst.req_addr", imem_req_addr, 32'h0000_0000);
    checkOutput("rst.if_valid", {31'b0, if_valid}, 32'd0);
    checkOutput("rst.if_instr", if_instr, 32'd0);
    checkOutput("rst.if_pc", if_pc, 32'd0);
    checkOutput("rst.fetch_fault", {31'b0, fetch_fault}, 32'd0);
  endtask

  initial begin
    // Streaming with 1-cycle memory, then a 10-cycle decode stall from cycle 6.
    for (int k = 0; k < 20; k++) begin
      vecs[k].reqReady    = 1'b1;
      vecs[k].rspValid    = 1'b0;
      vecs[k].rspData     = 32'h0;
      vecs[k].ifReady     = 1'b1;
      vecs[k].expReqValid = 1'b0;
      vecs[k].expReqAddr  = 32'h0;
      vecs[k].expIfValid  = 1'b0;
      vecs[k].expIfPc     = 32'h0;
      if (k <= 1) begin
        vecs[k].expReqValid = 1'b1;
        vecs[k].expReqAddr  = 32'(4 * k);
        if (k == 1) begin
          vecs[k].rspValid = 1'b1;
          vecs[k].rspData  = memWord(32'h0);
        end
      end else if (k <= 5) begin
        vecs[k].expReqValid = 1'b1;
        vecs[k].expReqAddr  = 32'(4 * k);
        vecs[k].rspValid    = 1'b1;
        vecs[k].rspData     = memWord(32'(4 * (k - 1)));
        vecs[k].expIfValid  = 1'b1;
        vecs[k].expIfPc     = 32'(4 * (k - 2));
      end else if (k <= 15) begin
        vecs[k].ifReady    = 1'b0;
        vecs[k].expIfValid = 1'b1;
        vecs[k].expIfPc    = 32'd16;
        if (k == 6) begin
          vecs[k].rspValid = 1'b1;
          vecs[k].rspData  = memWord(32'd20);
        end
      end else if (k == 16) begin
        vecs[k].expReqValid = 1'b1;
        vecs[k].expReqAddr  = 32'd24;
        vecs[k].expIfValid  = 1'b1;
        vecs[k].expIfPc     = 32'd16;
      end else begin
        vecs[k].expReqValid = 1'b1;
        vecs[k].expReqAddr  = 32'(4 * (k - 10));
        vecs[k].rspValid    = 1'b1;
        vecs[k].rspData     = memWord(32'(4 * (k - 11)));
        vecs[k].expIfValid  = 1'b1;
        vecs[k].expIfPc     = 32'(4 * (k - 12));
      end
    end

    doReset();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(vecs[k].reqReady, vecs[k].rspValid, vecs[k].rspData,
                    1'b0, 32'h0, vecs[k].ifReady);
      checkReq($sformatf("vec%0d", k), vecs[k].expReqValid, vecs[k].expReqAddr);
      checkIf($sformatf("vec%0d", k), vecs[k].expIfValid, vecs[k].expIfPc);
    end

    // 3-cycle memory: redirect to 0x100 with two stale requests in flight.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("lat3.c0", 1'b1, 32'h0);
    checkIf("lat3.c0", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("lat3.c1", 1'b1, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    checkReq("lat3.redir", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, memWord(32'h0), 1'b0, 32'h0, 1'b1);
    checkReq("lat3.c3", 1'b1, 32'h100);
    checkIf("lat3.c3", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
    checkReq("lat3.c4", 1'b1, 32'h104);
    checkIf("lat3.c4", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("lat3.c5", 1'b0, 32'h0);
    checkIf("lat3.c5", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, memWord(32'h100), 1'b0, 32'h0, 1'b1);
    checkIf("lat3.c6", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, memWord(32'h104), 1'b0, 32'h0, 1'b1);
    checkIf("lat3.c7", 1'b1, 32'h100);
    checkReq("lat3.c7", 1'b1, 32'h108);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkIf("lat3.c8", 1'b1, 32'h104);

    // Redirect coinciding with a response and a would-be decode transfer.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("coll.c0", 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b1, memWord(32'h0), 1'b0, 32'h0, 1'b1);
    checkReq("coll.c1", 1'b1, 32'h4);
    applyStimulus(1'b1, 1'b1, memWord(32'h4), 1'b1, 32'h40, 1'b1);
    checkReq("coll.redir", 1'b0, 32'h0);
    checkIf("coll.redir", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("coll.c3", 1'b1, 32'h40);
    checkIf("coll.c3", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, memWord(32'h40), 1'b0, 32'h0, 1'b1);
    checkReq("coll.c4", 1'b1, 32'h44);
    checkIf("coll.c4", 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, memWord(32'h44), 1'b0, 32'h0, 1'b1);
    checkIf("coll.c5", 1'b1, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkIf("coll.c6", 1'b1, 32'h44);

    // PC wraps from the top of the address space to zero.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checkReq("wrap.redir", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("wrap.top", 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkReq("wrap.zero", 1'b1, 32'h0000_0000);

    // Misaligned redirect, then recovery through an aligned redirect.
    doReset();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b1);
    checkReq("mis.redir", 1'b0, 32'h0);
    checkOutput("mis.redir.fault", {31'b0, fetch_fault}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("mis.c1.fault", {31'b0, fetch_fault}, 32'd1);
    checkReq("mis.c1", 1'b0, 32'h0);
`else
    checkOutput("mis.c1.fault", {31'b0, fetch_fault}, 32'd0);
    checkReq("mis.c1", 1'b1, 32'h100);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    checkReq("mis.redir2", 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("mis.c3.fault", {31'b0, fetch_fault}, 32'd0);
    checkReq("mis.c3", 1'b1, 32'h200);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
